bcd_div_sequencer: RTL and testbench

Sequencer that converts an 8-bit binary value to three BCD digits by driving the shared LogiCORE divide-by-10 datapath twice in succession. It sits between the data-generation logic and the divider core. It latches a binary operand on a start request, issues it to the divider, waits out the divider pipeline latency, and feeds the quotient back as the next dividend. It then presents hundreds/tens/ones digits with a one-cycle done strobe for the seven-segment path.

---
 rtl/bcd_div_sequencer.sv | 109 ++++++++++
 tb/tb_bcd_div_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bcd_div_sequencer.sv
// Converts an 8-bit binary value to three BCD digits with two passes through an external divide-by-10 pipeline.
// Optional BCDSEQ_LZB_EN adds a BLANK output that flags leading-zero digits.
module bcd_div_sequencer #(
  parameter int DIV_LAT = 12
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       START,
  input  logic [7:0] BIN,
  input  logic       RFD,
  input  logic [7:0] QUOTIENT,
  input  logic [7:0] FRACTIONAL,
  output logic       DCE,
  output logic [7:0] DIVIDEND,
  output logic [7:0] DIVISOR,
  output logic [3:0] BCD2,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0,
  output logic       BUSY,
  output logic       DONE
`ifdef BCDSEQ_LZB_EN
  ,
  output logic [2:0] BLANK
`endif
);

  localparam logic [5:0] LAT_M1 = 6'(DIV_LAT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, FINISH} state_t;

  state_t     state, state_nxt;
  logic       pass;
  logic [5:0] cnt;
  logic       unused_frac;

  assign DIVISOR     = 8'd10;
  assign unused_frac = ^FRACTIONAL[7:4];

  always_comb begin
    state_nxt = state;
    DCE       = 1'b0;
    DONE      = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      IDLE:    if (START) state_nxt = ISSUE;
      ISSUE: begin
        if (RFD) begin
          DCE       = 1'b1;
          state_nxt = (DIV_LAT == 1) ? CAPTURE : WAIT;
        end
      end
      // ISSUE plus DIV_LAT-1 WAIT cycles keeps DCE up for exactly DIV_LAT cycles
      WAIT: begin
        DCE = 1'b1;
        if (cnt <= 6'd1) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = pass ? FINISH : ISSUE;
      FINISH: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= IDLE;
      pass     <= 1'b0;
      cnt      <= 6'd0;
      DIVIDEND <= 8'd0;
      BCD2     <= 4'd0;
      BCD1     <= 4'd0;
      BCD0     <= 4'd0;
`ifdef BCDSEQ_LZB_EN
      BLANK    <= 3'b000;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (START) begin
            DIVIDEND <= BIN;
            pass     <= 1'b0;
          end
        end
        ISSUE: if (RFD) cnt <= LAT_M1;
        WAIT:  if (cnt != 6'd0) cnt <= cnt - 6'd1;
        CAPTURE: begin
          if (!pass) begin
            BCD0     <= FRACTIONAL[3:0];
            DIVIDEND <= QUOTIENT;
            pass     <= 1'b1;
          end else begin
            BCD1 <= FRACTIONAL[3:0];
            BCD2 <= QUOTIENT[3:0];
          end
        end
        FINISH: begin
`ifdef BCDSEQ_LZB_EN
          BLANK <= {(BCD2 == 4'd0), (BCD2 == 4'd0) && (BCD1 == 4'd0), 1'b0};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_div_sequencer.sv
// Bench for bcd_div_sequencer: behavioural divide-by-10 pipeline plus arithmetic digit model.
module tb_bcd_div_sequencer;
  localparam int L = 12;

  logic       CLK = 1'b0;
  logic       RSTN, START, RFD;
  logic [7:0] BIN, QUOTIENT, FRACTIONAL, DIVIDEND, DIVISOR;
  logic       DCE, BUSY, DONE;
  logic [3:0] BCD2, BCD1, BCD0;
`ifdef BCDSEQ_LZB_EN
  logic [2:0] BLANK;
`endif

  bcd_div_sequencer #(.DIV_LAT(L)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .BIN(BIN), .RFD(RFD),
    .QUOTIENT(QUOTIENT), .FRACTIONAL(FRACTIONAL), .DCE(DCE),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .BCD2(BCD2), .BCD1(BCD1),
    .BCD0(BCD0), .BUSY(BUSY), .DONE(DONE)
`ifdef BCDSEQ_LZB_EN
    , .BLANK(BLANK)
`endif
  );

  always #5 CLK = ~CLK;

  // Divider: operand sampled every edge, result appears L cycles later; invalid slots carry 238
  logic [7:0] pipe [L];
  always @(posedge CLK) begin
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= DCE ? DIVIDEND : 8'd238;
  end
  assign QUOTIENT   = pipe[L-1] / 8'd10;
  assign FRACTIONAL = {4'hA, 4'(pipe[L-1] % 8'd10)};

  int checks = 0;
  int failures = 0;
  int done_q[$];
  logic [11:0] dig_q[$];
  int run_q[$];
  logic [7:0] div_q[$];
  int dce_stall_bad;
  int run;
  logic zero_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] digits(input logic [7:0] b);
    return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
  endfunction

  // Drives one request starting at cycle 0 and records what the DUT shows each cycle.
  task automatic convert(input logic [7:0] bin, input int stall_from, input int stall_n,
                         input int restart_at, input logic [7:0] bin2, input logic hold,
                         input int rst_at, input int window);
    done_q.delete(); dig_q.delete(); run_q.delete(); div_q.delete();
    dce_stall_bad = 0; run = 0; zero_ok = 1'b0;
    @(posedge CLK); #1;
    START = 1'b1; BIN = bin; RFD = 1'b1; RSTN = 1'b1;
    for (int c = 0; c < window; c++) begin
      @(negedge CLK);
      if (DCE) begin
        if (run == 0) div_q.push_back(DIVIDEND);
        run++;
      end else if (run > 0) begin
        run_q.push_back(run);
        run = 0;
      end
      if (!RFD && DCE) dce_stall_bad++;
      if (DONE) begin
        done_q.push_back(c);
        dig_q.push_back({BCD2, BCD1, BCD0});
      end
      if (c == rst_at + 1)
        zero_ok = (DCE === 1'b0) && (DIVIDEND === 8'd0) && (BCD2 === 4'd0) && (BCD1 === 4'd0) &&
                  (BCD0 === 4'd0) && (BUSY === 1'b0) && (DONE === 1'b0);
      @(posedge CLK); #1;
      START = hold || (c + 1 == restart_at);
      if (c + 1 == restart_at) BIN = bin2;
      RFD  = !((c + 1) >= stall_from && (c + 1) < stall_from + stall_n);
      RSTN = !(c + 1 == rst_at);
    end
    START = 1'b0; RFD = 1'b1; RSTN = 1'b1;
  endtask

  task automatic check_conv(input string tag, input logic [7:0] bin, input int exp_done);
    check({tag, "_ndone"}, done_q.size(), 1);
    check({tag, "_done_cyc"}, (done_q.size() > 0) ? done_q[0] : -1, exp_done);
    check({tag, "_digits"}, (dig_q.size() > 0) ? dig_q[0] : 12'hFFF, digits(bin));
    check({tag, "_nruns"}, run_q.size(), 2);
    check({tag, "_run0"}, (run_q.size() > 0) ? run_q[0] : -1, L);
    check({tag, "_run1"}, (run_q.size() > 1) ? run_q[1] : -1, L);
    check({tag, "_div0"}, (div_q.size() > 0) ? div_q[0] : 8'hFF, bin);
    check({tag, "_div1"}, (div_q.size() > 1) ? div_q[1] : 8'hFF, bin / 8'd10);
    check({tag, "_dce_stall"}, dce_stall_bad, 0);
    check({tag, "_busy_after"}, BUSY, 1'b0);
`ifdef BCDSEQ_LZB_EN
    check({tag, "_blank"}, BLANK, {bin < 8'd100, bin < 8'd10, 1'b0});
`endif
  endtask

  initial begin
    RSTN = 1'b0; START = 1'b1; BIN = 8'h55; RFD = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_dce", DCE, 1'b0);
    check("rst_dividend", DIVIDEND, 8'd0);
    check("rst_divisor", DIVISOR, 8'd10);
    check("rst_bcd", {BCD2, BCD1, BCD0}, 12'd0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
`ifdef BCDSEQ_LZB_EN
    check("rst_blank", BLANK, 3'b000);
`endif
    @(posedge CLK); #1;
    RSTN = 1'b1; START = 1'b0;
    @(negedge CLK);
    check("start_in_rst_lost", BUSY, 1'b0);

    convert(8'd255, 0, 0, -5, 8'd0, 1'b0, -5, 30);
    check_conv("bin255", 8'd255, 2 * L + 3);
    check("divisor_idle", DIVISOR, 8'd10);

    convert(8'd0, 0, 0, -5, 8'd0, 1'b0, -5, 30);
    check_conv("bin0", 8'd0, 2 * L + 3);

    convert(8'd109, L + 2, 5, -5, 8'd0, 1'b0, -5, 35);
    check_conv("bin109_stall", 8'd109, 2 * L + 3 + 5);

    convert(8'd42, 0, 0, 10, 8'd99, 1'b0, -5, 40);
    check_conv("restart_ignored", 8'd42, 2 * L + 3);

    convert(8'd123, 0, 0, -5, 8'd0, 1'b0, L + 6, 40);
    check("rst_mid_zero", zero_ok, 1'b1);
    check("rst_mid_ndone", done_q.size(), 0);
    convert(8'd77, 0, 0, -5, 8'd0, 1'b0, -5, 30);
    check_conv("after_rst77", 8'd77, 2 * L + 3);

    convert(8'd200, 0, 0, -5, 8'd0, 1'b1, -5, 3 * (2 * L + 4));
    check("held_ndone", done_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("held_done_cyc", (done_q.size() > k) ? done_q[k] : -1, 2 * L + 3 + k * (2 * L + 4));
      check("held_digits", (dig_q.size() > k) ? dig_q[k] : 12'hFFF, digits(8'd200));
    end
    repeat (2) @(posedge CLK);

    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      int n, from;
      b    = 8'($urandom_range(0, 255));
      n    = $urandom_range(0, 6);
      from = ($urandom_range(0, 1) == 1) ? 1 : L + 2;
      convert(b, from, n, -5, 8'd0, 1'b0, -5, 32 + n);
      check_conv("rand", b, 2 * L + 3 + n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
